// File: rtl/sprite_pkg.sv
// Shared sprite constants: geometry, RAM widths, palette and frame base address helper.
package sprite_pkg;
  localparam int SPR_W       = 20;
  localparam int SPR_H       = 20;
  localparam int NUM_FRAMES  = 4;
  localparam int FRAME_TICKS = 8;
  localparam int TRANSP_IDX  = 0;
  localparam int ADDR_W      = 19;
  localparam int IDX_W       = 4;
  localparam int FIDX_W      = 2;

  // Entry order follows the PNG-to-hex converter output, index 0 first.
  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'hFFFFFF, 24'hE0281C, 24'hF8B800, 24'h3C8C1C, 24'h1C48C8,
    24'h8C3CB4, 24'hF07880, 24'h6C3C14, 24'hB8B8B8, 24'h545454, 24'hFCE0A8,
    24'h00A8A8, 24'hF83800, 24'h90D8FC, 24'h204020
  };

  function automatic logic [ADDR_W-1:0] frame_base(input logic [FIDX_W-1:0] idx);
    return ADDR_W'(idx) * ADDR_W'(SPR_W * SPR_H);
  endfunction
endpackage

// File: rtl/sprite_pixel_pipe_if.sv
// Scan-side, frameRAM-side and colour-output signals of the sprite pixel pipe.
interface sprite_pixel_pipe_if;
  import sprite_pkg::*;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              pixel_valid;
  logic              vsync_start;
  logic [9:0]        SpriteX;
  logic [9:0]        SpriteY;
  logic              anim_en;
  logic [IDX_W-1:0]  ram_data;
  logic [ADDR_W-1:0] read_address;
  logic [7:0]        Red;
  logic [7:0]        Green;
  logic [7:0]        Blue;
  logic              sprite_on;
  logic [FIDX_W-1:0] frame_idx;

  modport master (
    output DrawX, DrawY, pixel_valid, vsync_start, SpriteX, SpriteY, anim_en, ram_data,
    input  read_address, Red, Green, Blue, sprite_on, frame_idx
  );
  modport slave (
    input  DrawX, DrawY, pixel_valid, vsync_start, SpriteX, SpriteY, anim_en, ram_data,
    output read_address, Red, Green, Blue, sprite_on, frame_idx
  );
endinterface

// File: rtl/sprite_anim_ctr.sv
// Animation frame counter: advances frame_idx once every FRAME_TICKS enabled vsync pulses.
module sprite_anim_ctr #(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_TICKS = 8,
  parameter int FIDX_W      = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vsync_start,
  input  logic              anim_en,
  output logic [FIDX_W-1:0] frame_idx
);
  localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  logic [TICK_W-1:0] tick;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick      <= '0;
      frame_idx <= '0;
    end else if (vsync_start && anim_en) begin
      if (tick == TICK_W'(FRAME_TICKS - 1)) begin
        tick      <= '0;
        frame_idx <= (frame_idx == FIDX_W'(NUM_FRAMES - 1)) ? '0 : frame_idx + FIDX_W'(1);
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end
endmodule

// File: rtl/sprite_pixel_pipe.sv
// Scan position -> frameRAM address (combinational), palette index -> RGB two cycles later.
// Position and animation frame are latched only at vsync_start so a frame never tears.
module sprite_pixel_pipe
  import sprite_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  sprite_pixel_pipe_if.slave bus
);
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [FIDX_W-1:0] frame_idx;
  logic [10:0]       x11, y11, px11, py11;
  logic              hit;
  logic              hit_d1;
  logic              opaque;
  logic [23:0]       rgb;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (bus.vsync_start) begin
      pos_x <= bus.SpriteX;
      pos_y <= bus.SpriteY;
    end
  end

  sprite_anim_ctr #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FIDX_W      (FIDX_W)
  ) u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .vsync_start (bus.vsync_start),
    .anim_en     (bus.anim_en),
    .frame_idx   (frame_idx)
  );

  // One extra bit keeps pos+SPR_W from wrapping near the right/bottom screen edge.
  assign x11  = {1'b0, bus.DrawX};
  assign y11  = {1'b0, bus.DrawY};
  assign px11 = {1'b0, pos_x};
  assign py11 = {1'b0, pos_y};

  assign hit = bus.pixel_valid
            && (x11 >= px11) && (x11 < px11 + 11'(SPR_W))
            && (y11 >= py11) && (y11 < py11 + 11'(SPR_H));

  assign bus.read_address = hit
      ? frame_base(frame_idx) + ADDR_W'(y11 - py11) * ADDR_W'(SPR_W) + ADDR_W'(x11 - px11)
      : '0;

  assign opaque = hit_d1 && (bus.ram_data != IDX_W'(TRANSP_IDX));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_d1        <= 1'b0;
      bus.sprite_on <= 1'b0;
      rgb           <= '0;
    end else begin
      hit_d1        <= hit;
      bus.sprite_on <= opaque;
      rgb           <= opaque ? PALETTE[bus.ram_data] : 24'h000000;
    end
  end

  assign bus.Red       = rgb[23:16];
  assign bus.Green     = rgb[15:8];
  assign bus.Blue      = rgb[7:0];
  assign bus.frame_idx = frame_idx;
endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Self-checking bench for sprite_pixel_pipe: vector table plus a two-deep RGB scoreboard.
module tb_sprite_pixel_pipe;
  import sprite_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  sprite_pixel_pipe_if bus ();
  sprite_pixel_pipe dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pv;
    logic [3:0]  ram;
    logic        hit;
    logic [18:0] addr;
  } vec_t;

  typedef struct {
    logic [23:0] rgb;
    logic        on;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[11];
  int checks = 0;
  int errors = 0;
  logic [3:0] ram_next = 4'd0;
  int mdl_tick = 0;
  int mdl_frame = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic sb_restart();
    exp_t z;
    z.rgb = 24'h0;
    z.on  = 1'b0;
    sb.delete();
    sb.push_back(z);
    sb.push_back(z);
    ram_next  = 4'd0;
    mdl_tick  = 0;
    mdl_frame = 0;
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the next rising edge.
  task automatic run_px(input logic [9:0] x, input logic [9:0] y, input logic pv,
                        input logic vs, input logic an, input logic [3:0] ram,
                        input logic [9:0] spx, input logic [9:0] spy,
                        input logic hit_e, input logic [18:0] addr_e, input string nm);
    exp_t e;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk({nm, "_rgb"}, {8'h0, bus.Red, bus.Green, bus.Blue}, {8'h0, e.rgb});
      chk({nm, "_on"}, 32'(bus.sprite_on), 32'(e.on));
    end
    chk({nm, "_frame"}, 32'(bus.frame_idx), 32'(mdl_frame));
    bus.DrawX       = x;
    bus.DrawY       = y;
    bus.pixel_valid = pv;
    bus.vsync_start = vs;
    bus.anim_en     = an;
    bus.SpriteX     = spx;
    bus.SpriteY     = spy;
    bus.ram_data    = ram_next;
    ram_next        = ram;
    #1;
    chk({nm, "_addr"}, 32'(bus.read_address), 32'(addr_e));
    e.on  = hit_e && (ram != 4'(TRANSP_IDX));
    e.rgb = e.on ? PALETTE[ram] : 24'h0;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (vs && an) begin
      if (mdl_tick == FRAME_TICKS - 1) begin
        mdl_tick  = 0;
        mdl_frame = (mdl_frame == NUM_FRAMES - 1) ? 0 : mdl_frame + 1;
      end else begin
        mdl_tick++;
      end
    end
  endtask

  task automatic idle(input string nm);
    run_px(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 4'd0, bus.SpriteX, bus.SpriteY, 1'b0, 19'd0, nm);
  endtask

  initial begin
    tbl[0]  = '{10'd105, 10'd52, 1'b1, 4'd7,  1'b1, 19'd45};
    tbl[1]  = '{10'd99,  10'd52, 1'b1, 4'd3,  1'b0, 19'd0};
    tbl[2]  = '{10'd120, 10'd52, 1'b1, 4'd3,  1'b0, 19'd0};
    tbl[3]  = '{10'd119, 10'd52, 1'b1, 4'd9,  1'b1, 19'd59};
    tbl[4]  = '{10'd100, 10'd49, 1'b1, 4'd2,  1'b0, 19'd0};
    tbl[5]  = '{10'd100, 10'd69, 1'b1, 4'd2,  1'b1, 19'd380};
    tbl[6]  = '{10'd100, 10'd70, 1'b1, 4'd2,  1'b0, 19'd0};
    tbl[7]  = '{10'd105, 10'd52, 1'b0, 4'd2,  1'b0, 19'd0};
    tbl[8]  = '{10'd101, 10'd50, 1'b1, 4'd0,  1'b1, 19'd1};
    tbl[9]  = '{10'd102, 10'd50, 1'b1, 4'd5,  1'b1, 19'd2};
    tbl[10] = '{10'd100, 10'd50, 1'b1, 4'd15, 1'b1, 19'd0};

    // Reset held three cycles under random inputs.
    for (int i = 0; i < 3; i++) begin
      bus.DrawX       = 10'($urandom);
      bus.DrawY       = 10'($urandom);
      bus.pixel_valid = 1'($urandom);
      bus.vsync_start = 1'($urandom);
      bus.anim_en     = 1'($urandom);
      bus.SpriteX     = 10'($urandom);
      bus.SpriteY     = 10'($urandom);
      bus.ram_data    = 4'($urandom);
      @(posedge Clk);
      #1;
      chk("rst_rgb", {8'h0, bus.Red, bus.Green, bus.Blue}, 32'h0);
      chk("rst_on", 32'(bus.sprite_on), 32'h0);
      chk("rst_frame", 32'(bus.frame_idx), 32'h0);
    end
    bus.vsync_start = 1'b0;
    bus.pixel_valid = 1'b0;
    Reset = 1'b0;
    sb_restart();

    run_px(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 4'd0, 10'd100, 10'd50, 1'b0, 19'd0, "load_pos");

    foreach (tbl[i])
      run_px(tbl[i].x, tbl[i].y, tbl[i].pv, 1'b0, 1'b0, tbl[i].ram, 10'd100, 10'd50,
             tbl[i].hit, tbl[i].addr, $sformatf("vec%0d", i));
    idle("flush");

    // Animation: eight pulses per frame, wrap after four frames.
    for (int i = 0; i < 32; i++) begin
      run_px(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 4'd0, 10'd100, 10'd50, 1'b0, 19'd0, "anim_vs");
      if (i == 7) begin
        chk("anim_f1", 32'(bus.frame_idx), 32'd1);
        run_px(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 4'd3, 10'd100, 10'd50, 1'b1, 19'd400, "f1_base");
        run_px(10'd119, 10'd69, 1'b1, 1'b0, 1'b0, 4'd8, 10'd100, 10'd50, 1'b1, 19'd799, "f1_last");
      end
    end
    chk("anim_wrap", 32'(bus.frame_idx), 32'd0);
    for (int i = 0; i < 8; i++)
      run_px(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 4'd0, 10'd100, 10'd50, 1'b0, 19'd0, "anim_vs2");
    for (int i = 0; i < 10; i++)
      run_px(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 4'd0, 10'd100, 10'd50, 1'b0, 19'd0, "anim_hold");
    chk("anim_hold_f", 32'(bus.frame_idx), 32'd1);

    // Mid-frame SpriteX change stays invisible until the next vsync_start.
    run_px(10'd105, 10'd52, 1'b1, 1'b0, 1'b0, 4'd4,  10'd200, 10'd50, 1'b1, 19'd445, "tear_old");
    run_px(10'd205, 10'd52, 1'b1, 1'b0, 1'b0, 4'd4,  10'd200, 10'd50, 1'b0, 19'd0,   "tear_new_miss");
    run_px(10'd105, 10'd52, 1'b1, 1'b1, 1'b0, 4'd6,  10'd200, 10'd50, 1'b1, 19'd445, "vs_hit_old");
    run_px(10'd205, 10'd52, 1'b1, 1'b0, 1'b0, 4'd11, 10'd200, 10'd50, 1'b1, 19'd445, "tear_new");
    run_px(10'd105, 10'd52, 1'b1, 1'b0, 1'b0, 4'd11, 10'd200, 10'd50, 1'b0, 19'd0,   "tear_old_miss");
    run_px(10'd219, 10'd69, 1'b1, 1'b0, 1'b0, 4'd13, 10'd200, 10'd50, 1'b1, 19'd799, "tear_corner");

    // Reset asserted mid-line while opaque pixels are in flight.
    bus.DrawX    = 10'd206;
    bus.DrawY    = 10'd52;
    bus.ram_data = ram_next;
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_rgb", {8'h0, bus.Red, bus.Green, bus.Blue}, 32'h0);
    chk("midrst_on", 32'(bus.sprite_on), 32'h0);
    chk("midrst_frame", 32'(bus.frame_idx), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    sb_restart();
    run_px(10'd5, 10'd3, 1'b1, 1'b0, 1'b0, 4'd5, 10'd200, 10'd50, 1'b1, 19'd65, "post_rst");
    idle("post_rst_flush1");
    idle("post_rst_flush2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
